// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx
// Brief    : 16-bit stereo I2S transmitter, one-deep holding register,
//            underrun repeats the last frame. Define I2S_TX_UNDERRUN_FLAG_EN
//            to add the sticky underrun output.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx #(
  parameter int BCLK_DIV = 8
) (
  input  logic        clk24,
  input  logic        rst,
  input  logic [15:0] sample_l,
  input  logic [15:0] sample_r,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        bclk,
  output logic        lrck,
  output logic        sdata,
  output logic        frame_tick
`ifdef I2S_TX_UNDERRUN_FLAG_EN
  ,
  output logic        underrun
`endif
);

  localparam logic [7:0] c_div_last = 8'(BCLK_DIV - 1);

  logic [7:0]  r_div;
  logic        r_bclk;
  logic [4:0]  r_bitcnt;
  logic        r_lrck;
  logic        r_sdata;
  logic        r_tick;
  logic [31:0] r_shift;
  logic [31:0] r_hold;
  logic [31:0] r_last;
  logic        r_full;

  logic        w_wrap;
  logic        w_fall;
  logic [4:0]  w_next_cnt;
  logic        w_load;
  logic        w_xfer;
  logic [31:0] w_frame;

  assign w_wrap     = (r_div == c_div_last);
  assign w_fall     = w_wrap & r_bclk;
  assign w_next_cnt = r_bitcnt + 5'd1;
  assign w_load     = w_fall & (w_next_cnt == 5'd1);
  assign w_xfer     = in_valid & ~r_full;
  // An empty holding register at load time replays the previous frame.
  assign w_frame    = r_full ? r_hold : r_last;

  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      r_div    <= 8'd0;
      r_bclk   <= 1'b0;
      r_bitcnt <= 5'd0;
      r_lrck   <= 1'b0;
      r_sdata  <= 1'b0;
      r_tick   <= 1'b0;
      r_shift  <= 32'd0;
      r_hold   <= 32'd0;
      r_last   <= 32'd0;
      r_full   <= 1'b0;
    end else begin
      r_div  <= w_wrap ? 8'd0 : r_div + 8'd1;
      r_tick <= w_load;
      if (w_wrap) begin
        r_bclk <= ~r_bclk;
      end
      if (w_fall) begin
        r_bitcnt <= w_next_cnt;
        r_lrck   <= w_next_cnt[4];
        if (w_load) begin
          r_shift <= w_frame;
          r_sdata <= w_frame[31];
          r_last  <= w_frame;
        end else begin
          // Bit 31 already went out at load, so the next bit is bit 30.
          r_shift <= {r_shift[30:0], 1'b0};
          r_sdata <= r_shift[30];
        end
      end
      // A new pair never bypasses into the shifter on a load edge.
      if (w_xfer) begin
        r_hold <= {sample_l, sample_r};
        r_full <= 1'b1;
      end else if (w_load) begin
        r_full <= 1'b0;
      end
    end
  end

`ifdef I2S_TX_UNDERRUN_FLAG_EN
  logic r_underrun;

  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      r_underrun <= 1'b0;
    end else if (w_load && !r_full) begin
      r_underrun <= 1'b1;
    end
  end

  assign underrun = r_underrun;
`endif

  assign in_ready   = ~r_full;
  assign bclk       = r_bclk;
  assign lrck       = r_lrck;
  assign sdata      = r_sdata;
  assign frame_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tx
// Brief    : Self-checking bench for i2s_tx against a cycle-count based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_tx;

  localparam int D = 8;

  logic        clk24 = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample_l = 16'd0;
  logic [15:0] sample_r = 16'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        bclk;
  logic        lrck;
  logic        sdata;
  logic        frame_tick;
`ifdef I2S_TX_UNDERRUN_FLAG_EN
  logic        underrun;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  i2s_tx #(.BCLK_DIV(D)) dut (
    .clk24      (clk24),
    .rst        (rst),
    .sample_l   (sample_l),
    .sample_r   (sample_r),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bclk       (bclk),
    .lrck       (lrck),
    .sdata      (sdata),
    .frame_tick (frame_tick)
`ifdef I2S_TX_UNDERRUN_FLAG_EN
    ,
    .underrun   (underrun)
`endif
  );

  always #5 clk24 = ~clk24;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs follow from the edge count since reset release
  int          m_t;
  logic [31:0] m_q[$];
  logic [31:0] m_cur;
  logic        m_loaded;
  logic        m_under;
  logic        m_tick;
  logic        m_xfer;
  logic [31:0] m_pair;
  int          m_slot;
  logic        m_sd;

  always @(posedge clk24) begin
    if (rst) begin
      m_t = 0;
      m_q.delete();
      m_cur = 32'd0;
      m_loaded = 1'b0;
      m_under = 1'b0;
      m_tick = 1'b0;
    end else begin
      m_t++;
      m_xfer = in_valid && (m_q.size() == 0);
      m_pair = {sample_l, sample_r};
      m_tick = (m_t >= 2 * D) && (((m_t - 2 * D) % (64 * D)) == 0);
      if (m_tick) begin
        if (m_q.size() > 0) m_cur = m_q.pop_front();
        else m_under = 1'b1;
        m_loaded = 1'b1;
      end
      if (m_xfer) m_q.push_back(m_pair);
    end
    #1;
    m_slot = (m_t / (2 * D)) % 32;
    if (!m_loaded) m_sd = 1'b0;
    else if (m_slot == 0) m_sd = m_cur[0];
    else m_sd = m_cur[32 - m_slot];
    check("bclk", 32'(bclk), 32'((m_t / D) % 2));
    check("lrck", 32'(lrck), 32'(m_slot >= 16));
    check("sdata", 32'(sdata), 32'(m_sd));
    check("frame_tick", 32'(frame_tick), 32'(m_tick));
    check("in_ready", 32'(in_ready), 32'(m_q.size() == 0));
`ifdef I2S_TX_UNDERRUN_FLAG_EN
    check("underrun", 32'(underrun), 32'(m_under));
`endif
  end

  task automatic tick();
    @(posedge clk24);
    #1;
    cyc++;
  endtask

  task automatic wait_tick(output int at);
    int n = 0;
    while (!frame_tick && n < 600) begin
      tick();
      n++;
    end
    if (!frame_tick) check("wait_frame_tick_timeout", 32'(n), 32'd0);
    at = cyc;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    int n = 0;
    sample_l = l;
    sample_r = r;
    in_valid = 1'b1;
    while (n < 600) begin
      if (in_ready) begin
        tick();
        break;
      end
      tick();
      n++;
    end
    if (n >= 600) check("push_timeout", 32'(n), 32'd0);
    in_valid = 1'b0;
  endtask

  // Samples sdata/lrck at the next 32 bclk rising edges (mid-slot)
  task automatic capture(output logic [31:0] dw, output logic [31:0] lw, output int per);
    int rises = 0;
    int n = 0;
    int t0 = 0;
    int t1 = 0;
    logic prev;
    dw = 32'd0;
    lw = 32'd0;
    prev = bclk;
    while (rises < 32 && n < 700) begin
      tick();
      n++;
      if (bclk && !prev) begin
        dw = {dw[30:0], sdata};
        lw = {lw[30:0], lrck};
        rises++;
        if (rises == 1) t0 = cyc;
        if (rises == 2) t1 = cyc;
      end
      prev = bclk;
    end
    if (rises < 32) check("capture_timeout", 32'(rises), 32'd32);
    per = t1 - t0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dw;
    logic [31:0] lw;
    int per;
    int ta;
    int tb;
    int acc;

    // Reset release with the first pair already presented
    repeat (3) @(negedge clk24);
    sample_l = 16'hA5A5;
    sample_r = 16'h0F0F;
    in_valid = 1'b1;
    rst = 1'b0;
    cyc = 0;
    tick();
    in_valid = 1'b0;
    while (!frame_tick && cyc < 100) tick();
    check("first_tick_cycle", 32'(cyc), 32'd16);
    ta = cyc;
    capture(dw, lw, per);
    check("word_A5A5_0F0F", dw, 32'hA5A50F0F);
    check("lrck_pattern", lw, 32'h0001FFFE);
    check("bclk_period", 32'(per), 32'd16);
    wait_tick(tb);
    check("frame_tick_period", 32'(tb - ta), 32'd512);

    // Underrun repeats the last pair
    push(16'h8000, 16'h7FFF);
    for (int f = 0; f < 3; f++) begin
      wait_tick(ta);
      capture(dw, lw, per);
      check("repeat_8000_7FFF", dw, 32'h80007FFF);
    end
`ifdef I2S_TX_UNDERRUN_FLAG_EN
    check("underrun_sticky", 32'(underrun), 32'd1);
`endif

    // Transfer on the exact load edge
    wait_tick(ta);
    repeat (511) tick();
    sample_l = 16'h1234;
    sample_r = 16'hABCD;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("coincident_tick", 32'(frame_tick), 32'd1);
    check("coincident_in_ready", 32'(in_ready), 32'd0);
    capture(dw, lw, per);
    check("coincident_old_pair", dw, 32'h80007FFF);
    wait_tick(ta);
    capture(dw, lw, per);
    check("coincident_new_pair", dw, 32'h1234ABCD);

    // Continuous valid for 8 frames: exactly one pair per frame
    wait_tick(ta);
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 8 * 512; i++) begin
      sample_l = 16'($urandom);
      sample_r = 16'($urandom);
      if (in_valid && in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    check("pairs_accepted_8_frames", 32'(acc), 32'd8);

    // Sparse random traffic, mixing fresh frames with underruns
    for (int i = 0; i < 4 * 512; i++) begin
      sample_l = 16'($urandom);
      sample_r = 16'($urandom);
      in_valid = ($urandom_range(0, 63) == 0);
      tick();
    end
    in_valid = 1'b0;

    // Reset in the middle of slot 20
    wait_tick(ta);
    push(16'h5555, 16'hAAAA);
    repeat (19 * 16 + 2) tick();
    check("lrck_before_rst", 32'(lrck), 32'd1);
    check("in_ready_before_rst", 32'(in_ready), 32'd0);
    @(negedge clk24);
    rst = 1'b1;
    #1;
    check("rst_bclk", 32'(bclk), 32'd0);
    check("rst_lrck", 32'(lrck), 32'd0);
    check("rst_sdata", 32'(sdata), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_frame_tick", 32'(frame_tick), 32'd0);
    repeat (2) @(negedge clk24);
    rst = 1'b0;
    cyc = 0;
    tick();
    while (!frame_tick && cyc < 100) tick();
    check("tick_after_rst", 32'(cyc), 32'd16);
    capture(dw, lw, per);
    check("frame_after_rst", dw, 32'h00000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 The module SHALL have one parameter: BCLK_DIV, default 8, number of clk24 cycles per BCLK half-period (legal range 1..255).
REQ-002 Port: clk24  in  1  system clock, 24 MHz; all logic SHALL be clocked by its rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-high reset.
REQ-004 Port: sample_l  in  16  left-channel sample, two's complement.
REQ-005 Port: sample_r  in  16  right-channel sample, two's complement.
REQ-006 Port: in_valid  in  1  sample_l/sample_r pair valid.
REQ-007 Port: in_ready  out  1  holding register empty; a transfer occurs when in_valid and in_ready are both high on a clk24 edge.
REQ-008 Port: bclk  out  1  I2S bit clock.
REQ-009 Port: lrck  out  1  I2S word select; 0 = left, 1 = right.
REQ-010 Port: sdata  out  1  I2S serial data, MSB first.
REQ-011 Port: frame_tick  out  1  one-clk24 pulse when a new frame is loaded into the shifter.

Function
REQ-012 A divider SHALL count 0..BCLK_DIV-1 and toggle bclk on each wrap, giving a BCLK period of 2*BCLK_DIV clk24 cycles (BCLK_DIV=8: 1.5 MHz, fs 46.875 kHz).
REQ-013 Each BCLK falling edge SHALL be a slot boundary; bitcnt (5 bits) SHALL increment modulo 32 there, and sdata/lrck SHALL update on the same clk24 edge on which bclk goes low.
REQ-014 lrck SHALL be 0 during slots 0..15 and 1 during slots 16..31.
REQ-015 At the boundary entering slot 1, the 32-bit shifter SHALL load {L,R} and frame_tick SHALL pulse for exactly one clk24 cycle.
REQ-016 sdata SHALL carry L[15..0] in slots 1..16, R[15..1] in slots 17..31, and R[0] in slot 0 of the following frame (standard one-BCLK I2S delay).
REQ-017 One 32-bit holding register SHALL sit between the handshake and the shifter; in_ready SHALL be high exactly when it is empty.
REQ-018 At a load, if the holding register is full, its contents SHALL be loaded and it SHALL become empty on that same edge.
REQ-019 If a transfer and a load occur on the same edge, the shifter SHALL take the old holding contents and the holding register SHALL capture the new pair, remaining full.
REQ-020 Underrun: at a load with the holding register empty, the shifter SHALL reload the previously transmitted {L,R}.
REQ-021 When in_ready is low, in_valid SHALL be ignored and the holding register SHALL NOT be overwritten.

Reset
REQ-022 While rst is high: bclk=0, lrck=0, sdata=0, frame_tick=0, in_ready=1, bitcnt=0, divider=0, shifter=0, holding register empty, last-frame register=0.
REQ-023 Assertion mid-frame SHALL force all outputs to their reset values immediately, with no completion of the current frame.
REQ-024 After release, the first bclk rising edge SHALL occur BCLK_DIV cycles later, and the first load SHALL occur 2*BCLK_DIV cycles after release.

Configuration
REQ-025 Macro I2S_TX_UNDERRUN_FLAG_EN: when defined, the module SHALL add output port underrun (1 bit), sticky-set on any REQ-020 event and cleared only by rst.
REQ-026 Without I2S_TX_UNDERRUN_FLAG_EN, the underrun port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-027 BCLK_DIV=8, load L=16'hA5A5, R=16'h0F0F -> sdata slots 1..16 = 1010010110100101, slots 17..31 then next slot 0 = 0000111100001111; lrck toggles at slots 0/16.
REQ-028 Clock check -> bclk period 16 clk24 cycles; frame_tick period 512 cycles; one pulse per frame.
REQ-029 Hold in_valid=1 with changing data -> in_ready low after the first transfer; only one pair accepted per frame; no pair lost or duplicated over 8 frames.
REQ-030 Load 16'h8000/16'h7FFF, then in_valid=0 for 3 frames -> same bit pattern repeated each frame; underrun=1 when the macro is defined.
REQ-031 Assert rst at slot 20 -> bclk/lrck/sdata=0 and in_ready=1 within the same cycle; after release the first frame_tick occurs at cycle 16.
REQ-032 Transfer on the exact load edge -> the shifter gets the old pair, the holding register keeps the new pair, and in_ready stays low.
